// File: rtl/periph_hub.sv
`default_nettype none
// ============================================================================
// periph_hub : memory-mapped LED/switch/button/7-segment hub with an optional
//              compare timer (enabled by defining PERIPH_HUB_TIMER_EN).
// Revision   : 1.0
// ============================================================================
module periph_hub #(
   parameter int LED_W        = 5,
   parameter int SW_W         = 5,
   parameter int BTN_W        = 5,
   parameter int DIGITS       = 4,
   parameter int DEBOUNCE_CYC = 250000,
   parameter int SCAN_DIV     = 100000,
   parameter int ADDR_W       = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] A,
   input  logic [31:0]       WD,
   input  logic              WE,
   output logic [31:0]       RD,
   input  logic [BTN_W-1:0]  btn,
   input  logic [SW_W-1:0]   sw,
   output logic [LED_W-1:0]  led,
   output logic [6:0]        HEX,
   output logic [DIGITS-1:0] HEX_Selector,
   output logic              timer_irq
);

   localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int WA_W = ADDR_W - 2;

   localparam logic [WA_W-1:0] c_idx_led   = WA_W'(0);
   localparam logic [WA_W-1:0] c_idx_sw    = WA_W'(1);
   localparam logic [WA_W-1:0] c_idx_btn   = WA_W'(2);
   localparam logic [WA_W-1:0] c_idx_edge  = WA_W'(3);
   localparam logic [WA_W-1:0] c_idx_hval  = WA_W'(4);
   localparam logic [WA_W-1:0] c_idx_hen   = WA_W'(5);
   localparam logic [WA_W-1:0] c_idx_tctrl = WA_W'(6);
   localparam logic [WA_W-1:0] c_idx_tcnt  = WA_W'(7);
   localparam logic [WA_W-1:0] c_idx_tcmp  = WA_W'(8);

   function automatic logic [6:0] hex_font(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;   4'h1: s = 7'h79;   4'h2: s = 7'h24;   4'h3: s = 7'h30;
         4'h4: s = 7'h19;   4'h5: s = 7'h12;   4'h6: s = 7'h02;   4'h7: s = 7'h78;
         4'h8: s = 7'h00;   4'h9: s = 7'h10;   4'hA: s = 7'h08;   4'hB: s = 7'h03;
         4'hC: s = 7'h46;   4'hD: s = 7'h21;   4'hE: s = 7'h06;   default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic [WA_W-1:0] wa;
   assign wa = A[ADDR_W-1:2];

   // Byte-lane bits and write-data bits wider than any register are don't-care.
   logic unused_bits;
   assign unused_bits = ^{A[1:0], WD};

   logic [LED_W-1:0]             led_q, led_d;
   logic [SW_W-1:0]              sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic [BTN_W-1:0]             btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic [BTN_W-1:0]             btn_lvl_q, btn_lvl_d;
   logic [BTN_W-1:0]             btn_edge_q, btn_edge_d;
   logic [BTN_W-1:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [4*DIGITS-1:0]          hex_val_q, hex_val_d;
   logic [DIGITS-1:0]            hex_en_q, hex_en_d;
   logic [SC_W-1:0]              scan_cnt_q, scan_cnt_d;
   logic [IX_W-1:0]              scan_idx_q, scan_idx_d;
   logic [6:0]                   seg_q, seg_d;
   logic [DIGITS-1:0]            sel_q, sel_d;

   always_comb begin
      led_d      = led_q;
      hex_val_d  = hex_val_q;
      hex_en_d   = hex_en_q;
      sw_s1_d    = sw;
      sw_s2_d    = sw_s1_q;
      btn_s1_d   = btn;
      btn_s2_d   = btn_s1_q;
      btn_lvl_d  = btn_lvl_q;
      db_cnt_d   = db_cnt_q;
      btn_edge_d = btn_edge_q;

      if (WE && wa == c_idx_led)  led_d     = WD[LED_W-1:0];
      if (WE && wa == c_idx_hval) hex_val_d = WD[4*DIGITS-1:0];
      if (WE && wa == c_idx_hen)  hex_en_d  = WD[DIGITS-1:0];

      // A level flips only after DEBOUNCE_CYC consecutive disagreeing samples.
      for (int i = 0; i < BTN_W; i++) begin
         if (btn_s2_q[i] == btn_lvl_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
            btn_lvl_d[i] = ~btn_lvl_q[i];
            db_cnt_d[i]  = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end

      if (WE && wa == c_idx_edge) btn_edge_d = btn_edge_d & ~WD[BTN_W-1:0];
      btn_edge_d = btn_edge_d | (btn_lvl_d & ~btn_lvl_q);
   end

   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      scan_idx_d = scan_idx_q;
      if (scan_cnt_q == SC_W'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         scan_idx_d = (scan_idx_q == IX_W'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
      end

      // Segment data comes from the post-write register values so CPU updates show next cycle.
      seg_d = 7'h7F;
      sel_d = '1;
      if (hex_en_d[scan_idx_q]) begin
         sel_d = ~(DIGITS'(1) << scan_idx_q);
         seg_d = hex_font(hex_val_d[4*int'(scan_idx_q) +: 4]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led_q      <= '0;
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         btn_s1_q   <= '0;
         btn_s2_q   <= '0;
         btn_lvl_q  <= '0;
         btn_edge_q <= '0;
         db_cnt_q   <= '0;
         hex_val_q  <= '0;
         hex_en_q   <= '1;
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
         seg_q      <= 7'h7F;
         sel_q      <= '1;
      end else begin
         led_q      <= led_d;
         sw_s1_q    <= sw_s1_d;
         sw_s2_q    <= sw_s2_d;
         btn_s1_q   <= btn_s1_d;
         btn_s2_q   <= btn_s2_d;
         btn_lvl_q  <= btn_lvl_d;
         btn_edge_q <= btn_edge_d;
         db_cnt_q   <= db_cnt_d;
         hex_val_q  <= hex_val_d;
         hex_en_q   <= hex_en_d;
         scan_cnt_q <= scan_cnt_d;
         scan_idx_q <= scan_idx_d;
         seg_q      <= seg_d;
         sel_q      <= sel_d;
      end
   end

   assign led          = led_q;
   assign HEX          = seg_q;
   assign HEX_Selector = sel_q;

`ifdef PERIPH_HUB_TIMER_EN
   logic        tmr_en_q, tmr_en_d;
   logic        tmr_flag_q, tmr_flag_d;
   logic [31:0] tcnt_q, tcnt_d;
   logic [31:0] tcmp_q, tcmp_d;

   always_comb begin
      tmr_en_d   = tmr_en_q;
      tmr_flag_d = tmr_flag_q;
      tcnt_d     = tcnt_q;
      tcmp_d     = tcmp_q;
      if (WE && wa == c_idx_tctrl) begin
         tmr_en_d = WD[0];
         if (WD[1]) tmr_flag_d = 1'b0;
      end
      if (WE && wa == c_idx_tcmp) tcmp_d = WD;
      if (tmr_en_q) begin
         if (tcnt_q == tcmp_q) begin
            tcnt_d     = '0;
            tmr_flag_d = 1'b1;
         end else begin
            tcnt_d = tcnt_q + 32'd1;
         end
      end
      // A CPU write to the count overrides the increment or wrap.
      if (WE && wa == c_idx_tcnt) tcnt_d = WD;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tmr_en_q   <= 1'b0;
         tmr_flag_q <= 1'b0;
         tcnt_q     <= '0;
         tcmp_q     <= '0;
      end else begin
         tmr_en_q   <= tmr_en_d;
         tmr_flag_q <= tmr_flag_d;
         tcnt_q     <= tcnt_d;
         tcmp_q     <= tcmp_d;
      end
   end

   assign timer_irq = tmr_flag_q & tmr_en_q;
`else
   assign timer_irq = 1'b0;
`endif

   always_comb begin
      RD = '0;
      case (wa)
         c_idx_led:   RD = 32'(led_q);
         c_idx_sw:    RD = 32'(sw_s2_q);
         c_idx_btn:   RD = 32'(btn_lvl_q);
         c_idx_edge:  RD = 32'(btn_edge_q);
         c_idx_hval:  RD = 32'(hex_val_q);
         c_idx_hen:   RD = 32'(hex_en_q);
`ifdef PERIPH_HUB_TIMER_EN
         c_idx_tctrl: RD = {30'd0, tmr_flag_q, tmr_en_q};
         c_idx_tcnt:  RD = tcnt_q;
         c_idx_tcmp:  RD = tcmp_q;
`endif
         default:     RD = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: doc/periph_hub.md
Name: periph_hub

Overview:
- Parametrised memory-mapped peripheral subsystem for the single-cycle RISC-V SoC. Sits on the data-side bus beside data_memory and is selected when the address decode picks the peripheral region.
- Generalises the fixed 5-LED/5-switch/4-digit peripheral set to configurable widths and digit count.
- Adds button debouncing, sticky edge capture, blanking-mask 7-segment scanning, and an optional compare timer.

Parameters:
LED_W, 5, number of LED outputs
SW_W, 5, number of switch inputs
BTN_W, 5, number of button inputs
DIGITS, 4, number of 7-segment digits (1..8)
DEBOUNCE_CYC, 250000, consecutive stable cycles required before a debounced button level changes
SCAN_DIV, 100000, clock cycles each digit is displayed
ADDR_W, 6, byte-address width; A[1:0] ignored

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
A  in  ADDR_W  byte address within peripheral region
WD  in  32  write data
WE  in  1  write enable, sampled at posedge clk
RD  out  32  read data, combinational from A
btn  in  BTN_W  raw asynchronous buttons
sw  in  SW_W  raw asynchronous switches
led  out  LED_W  LED drive
HEX  out  7  segments {g,f,e,d,c,b,a}, active-low
HEX_Selector  out  DIGITS  digit anodes, active-low one-hot
timer_irq  out  1  timer flag level

Behaviour:
- One clock domain. Reset is synchronous and active-low: rst_n is sampled at posedge clk.
- Register map (word offsets):
  - 0x00 LED: RW, bits[LED_W-1:0].
  - 0x04 SW: RO, synchronised switches.
  - 0x08 BTN: RO, debounced button levels.
  - 0x0C BTN_EDGE: RW1C, sticky debounced rising edges.
  - 0x10 HEX_VAL: RW, 4*DIGITS bits. Nibble i drives digit i.
  - 0x14 HEX_EN: RW, DIGITS bits. Per-digit enable mask.
  - 0x18 TCTRL, 0x1C TCNT, 0x20 TCMP: timer registers, see Optional Feature.
- Unmapped offsets read 0; writes to them are ignored. Unused upper bits read 0.
- Reads are combinational with zero latency. A write takes effect at the posedge where WE=1, so a read in the next cycle returns the new value.
- Reset values:
  - LED=0, led=0.
  - HEX_VAL=0, HEX_EN=all ones.
  - BTN=0, BTN_EDGE=0.
  - Synchronisers=0, debounce counters=0, scan index=0, scan counter=0.
  - HEX=7'h7F and HEX_Selector=all ones (display dark) while rst_n=0.
- sw and btn pass through 2-FF synchronisers. The SW register shows the synchronised value: 2 cycles of latency.
- Debounce, per button:
  - Counter clears whenever the synchronised input equals BTN[i].
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYC-1, BTN[i] toggles and the counter clears.
  - Minimum latency from a raw change to BTN: DEBOUNCE_CYC+2 cycles.
- Edge capture: BTN_EDGE[i] sets in the cycle BTN[i] goes 0->1. A write of 1 clears the bit. If a set and a clear hit the same bit in the same cycle, set wins.
- Scan:
  - A counter counts 0..SCAN_DIV-1; on wrap the scan index advances and wraps from DIGITS-1 to 0.
  - Outputs are registered: each cycle HEX_Selector = ~(1<<index) when HEX_EN[index]=1, else all ones.
  - HEX = hex font of nibble[index], covering 0-9 and A-F with standard encodings (0 -> 7'h40, 1 -> 7'h79, F -> 7'h0E).
  - A disabled digit drives HEX=7'h7F.
- Writing HEX_VAL or HEX_EN mid-scan takes effect on the next cycle's output; the scan position is unaffected.
- Reset asserted mid-operation clears all state in that cycle; no partial write completes.

Optional Feature:
- Macro: PERIPH_HUB_TIMER_EN.
- When defined:
  - TCTRL bit0=enable, bit1=flag (RW1C). TCNT and TCMP are 32-bit RW. Reset value of all three is 0.
  - While enabled, each cycle: if TCNT==TCMP then TCNT<=0 and flag<=1, else TCNT<=TCNT+1.
  - A CPU write to TCNT has priority over the increment.
  - timer_irq = flag & enable.
  - If a flag set and a W1C clear occur in the same cycle, set wins.
- When undefined: offsets 0x18-0x20 read 0, writes are ignored, timer_irq is tied 0, and no timer logic is synthesised.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release -> led=0, HEX_Selector=4'hF during reset, RD@0x14=0xF, RD@0x0C=0.
- Write 0x15 to 0x00 -> next cycle led=5'h15 and RD@0x00=0x15. Write to 0x24 -> RD@0x24=0 and no register changes.
- DEBOUNCE_CYC=4: pulse btn[2] high for 3 cycles -> BTN stays 0. Hold high for 8 cycles -> BTN[2]=1 within 6 cycles; RD@0x0C=0x4. Write 0x4 to 0x0C -> reads 0. Clear coinciding with a new edge -> bit stays 1.
- SCAN_DIV=2, HEX_VAL=0x1F30, HEX_EN=0xB:
  - Digit0 drives HEX=7'h40 with sel=4'hE.
  - Digit1 drives 7'h30 with sel=4'hD.
  - Digit2 is dark: sel=4'hF, HEX=7'h7F.
  - Digit3 drives 7'h79 with sel=4'h7.
  - Each digit lasts 2 cycles.
- PERIPH_HUB_TIMER_EN defined, TCMP=3, TCTRL=1:
  - TCNT sequence is 0,1,2,3,0.
  - flag and timer_irq rise the cycle after TCNT=3.
  - Writing 0x3 to TCTRL clears flag and keeps enable.
- PERIPH_HUB_TIMER_EN undefined: write 5 to 0x1C -> RD@0x1C=0, timer_irq=0.
